// File: rtl/bldcm_ramp_master.sv
// bldcm_ramp_master: Avalon-MM initiator that ramps the mBldcm driver's commutation
// frequency toward a target, reading back the driver status after every frequency write.
module bldcm_ramp_master #(
  parameter logic [31:0] pStepSize    = 32'd1000,
  parameter logic [31:0] pStepPeriod  = 32'd50000,
  parameter logic [31:0] pStartFreq   = 32'd0,
  parameter int unsigned pReadLatency = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [31:0] iTargetFreq,
  output logic        oBusy,
  output logic        oAtTarget,
  output logic        oError,
  output logic [31:0] oCurFreq,
  output logic [31:0] oStatus,
  output logic [1:0]  oAddr,
  output logic        oRead,
  input  logic [31:0] iRdata,
  output logic        oWrite,
  output logic [31:0] oWdata,
  input  logic [1:0]  iResp
);

  localparam logic [1:0]  AddrFreq  = 2'd0;
  localparam logic [1:0]  AddrEn    = 2'd2;
  localparam logic [1:0]  AddrStat  = 2'd3;
  localparam logic [31:0] RdLast    = 32'(pReadLatency - 1);
  localparam logic [31:0] WaitLast  = pStepPeriod - 32'd1;

  typedef enum logic [3:0] {
    StIdle, StWrFreq, StWrEn, StWait, StStep, StRdStat, StRdWait, StHold, StWrDis, StError
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_cur;
  logic [31:0] r_status;
  logic        r_error;
  logic        r_first;     // ramp just started: enable write still owed after the freq write
  logic        r_stop_pend; // stop seen while a read was outstanding
  logic        r_read;
  logic        r_write;
  logic [1:0]  r_addr;
  logic [31:0] r_wdata;

  logic [32:0] w_up_diff;
  logic [32:0] w_dn_diff;
  logic [31:0] w_next;

  // Next ramp frequency: step toward the target, clamping on the last step.
  always_comb begin
    w_up_diff = {1'b0, iTargetFreq} - {1'b0, r_cur};
    w_dn_diff = {1'b0, r_cur} - {1'b0, iTargetFreq};
    w_next    = r_cur;
    if (r_cur < iTargetFreq) begin
      w_next = (w_up_diff <= {1'b0, pStepSize}) ? iTargetFreq : r_cur + pStepSize;
    end else if (r_cur > iTargetFreq) begin
      w_next = (w_dn_diff <= {1'b0, pStepSize}) ? iTargetFreq : r_cur - pStepSize;
    end
  end

  // Control FSM with registered bus strobes; strobes default low every cycle.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_status    <= '0;
      r_error     <= 1'b0;
      r_first     <= 1'b0;
      r_stop_pend <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      unique case (r_state)
        StIdle, StError: begin
          // ERROR ignores iStop, so a start there is never vetoed
          if (iStart && (!iStop || r_state == StError)) begin
            r_error     <= 1'b0;
            r_cur       <= pStartFreq;
            r_first     <= 1'b1;
            r_stop_pend <= 1'b0;
            r_write     <= 1'b1;
            r_addr      <= AddrFreq;
            r_wdata     <= pStartFreq;
            r_state     <= StWrFreq;
          end
        end
        StWrFreq, StWrEn: begin
          if (iStop || r_stop_pend) begin
            r_write <= 1'b1;
            r_addr  <= AddrEn;
            r_state <= StWrDis;
          end else if (r_state == StWrFreq && r_first) begin
            r_first <= 1'b0;
            r_write <= 1'b1;
            r_addr  <= AddrEn;
            r_wdata <= 32'd1;
            r_state <= StWrEn;
          end else begin
            r_read  <= 1'b1;
            r_addr  <= AddrStat;
            r_state <= StRdStat;
          end
        end
        StRdStat: begin
          r_cnt   <= '0;
          r_state <= StRdWait;
          if (iStop) r_stop_pend <= 1'b1;
        end
        StRdWait: begin
          if (r_cnt != RdLast) begin
            r_cnt <= r_cnt + 32'd1;
            if (iStop) r_stop_pend <= 1'b1;
          end else if (iStop || r_stop_pend) begin
            // read completes but its data is dropped
            r_write <= 1'b1;
            r_addr  <= AddrEn;
            r_state <= StWrDis;
          end else begin
            r_status <= iRdata;
            if (iResp != 2'b00) begin
              r_error <= 1'b1;
              r_write <= 1'b1;
              r_addr  <= AddrEn;
              r_state <= StWrDis;
            end else if (r_cur == iTargetFreq) begin
              r_state <= StHold;
            end else begin
              r_cnt   <= '0;
              r_state <= StWait;
            end
          end
        end
        StWait, StStep, StHold: begin
          if (iStop) begin
            r_write <= 1'b1;
            r_addr  <= AddrEn;
            r_state <= StWrDis;
          end else if (r_state == StWait) begin
            if (r_cnt == WaitLast) r_state <= StStep;
            else                   r_cnt   <= r_cnt + 32'd1;
          end else if (r_state == StStep) begin
            r_cur   <= w_next;
            r_write <= 1'b1;
            r_addr  <= AddrFreq;
            r_wdata <= w_next;
            r_state <= StWrFreq;
          end else if (iTargetFreq != r_cur) begin
            r_cnt   <= '0;
            r_state <= StWait;
          end
        end
        StWrDis: begin
          r_stop_pend <= 1'b0;
          r_state     <= r_error ? StError : StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oBusy     = (r_state != StIdle) && (r_state != StError);
  assign oAtTarget = (r_state == StHold);
  assign oError    = r_error;
  assign oCurFreq  = r_cur;
  assign oStatus   = r_status;
  assign oAddr     = r_addr;
  assign oRead     = r_read;
  assign oWrite    = r_write;
  assign oWdata    = r_wdata;

endmodule

// File: tb/tb_bldcm_ramp_master.sv
// tb_bldcm_ramp_master: randomized scenarios checked against a step-count ramp model.
module tb_bldcm_ramp_master;

  localparam logic [31:0] STEP  = 32'd1000;
  localparam logic [31:0] PER   = 32'd4;
  localparam logic [31:0] START = 32'd0;
  localparam int          LAT   = 1;
  localparam int          CAD   = 4 + 3 + LAT;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic        iStop  = 1'b0;
  logic [31:0] iTargetFreq = '0;
  logic        oBusy, oAtTarget, oError, oRead, oWrite;
  logic [31:0] oCurFreq, oStatus, oWdata;
  logic [1:0]  oAddr;
  logic [31:0] iRdata = '0;
  logic [1:0]  iResp  = '0;

  bldcm_ramp_master #(
    .pStepSize(STEP), .pStepPeriod(PER), .pStartFreq(START), .pReadLatency(LAT)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iStop(iStop),
    .iTargetFreq(iTargetFreq), .oBusy(oBusy), .oAtTarget(oAtTarget), .oError(oError),
    .oCurFreq(oCurFreq), .oStatus(oStatus), .oAddr(oAddr), .oRead(oRead),
    .iRdata(iRdata), .oWrite(oWrite), .oWdata(oWdata), .iResp(iResp)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    bit        rd;
    bit [1:0]  addr;
    bit [31:0] data;
    int        cyc;
  } op_t;

  op_t         log_q[$];
  op_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          reads_seen = 0;
  int          err_on_read = 0;
  bit          err_armed = 0;
  logic [31:0] last_status = '0;
  logic [31:0] cur_model = '0;

  always @(posedge iClock) cyc <= cyc + 1;

  // Bus monitor, protocol check and slave with one cycle of read latency.
  always @(negedge iClock) begin
    op_t o;
    checks++;
    if ((oRead && oWrite) || (!oRead && !oWrite && (oAddr !== 2'd0 || oWdata !== 32'd0))) begin
      failures++;
      $display("FAIL bus_protocol cyc=%0d: rd=%0b wr=%0b addr=%0d wdata=%0d, required one strobe max and zero idle bus",
               cyc, oRead, oWrite, oAddr, oWdata);
    end
    if (oRead || oWrite) begin
      o.rd = oRead; o.addr = oAddr; o.data = oRead ? 32'd0 : oWdata; o.cyc = cyc;
      log_q.push_back(o);
    end
    if (oRead) begin
      reads_seen++;
      iRdata = $urandom;
      iResp  = (err_armed && reads_seen == err_on_read) ? 2'b10 : 2'b00;
      last_status = iRdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge iClock); #1; end
  endtask

  task automatic push_op(input bit rd, input bit [1:0] a, input bit [31:0] d);
    op_t o;
    o.rd = rd; o.addr = a; o.data = d; o.cyc = 0;
    exp_q.push_back(o);
  endtask

  // Ramp as n = ceil(|t-from|/STEP) writes, the k-th at from +/- k*STEP, the last at t.
  task automatic exp_ramp(input logic [31:0] from, input logic [31:0] t);
    longint d;
    longint n;
    longint f;
    d = (t > from) ? longint'(t) - longint'(from) : longint'(from) - longint'(t);
    n = (d + longint'(STEP) - 1) / longint'(STEP);
    for (longint k = 1; k <= n; k++) begin
      if (k == n)       f = longint'(t);
      else if (t > from) f = longint'(from) + k * longint'(STEP);
      else              f = longint'(from) - k * longint'(STEP);
      push_op(1'b0, 2'd0, 32'(f));
      push_op(1'b1, 2'd3, 32'd0);
    end
  endtask

  task automatic exp_start(input logic [31:0] t);
    push_op(1'b0, 2'd0, START);
    push_op(1'b0, 2'd2, 32'd1);
    push_op(1'b1, 2'd3, 32'd0);
    exp_ramp(START, t);
  endtask

  task automatic wait_hold(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (oAtTarget) ok = 1'b1;
    end
  endtask

  task automatic pulse_start();
    iStart = 1'b1; tick(1); iStart = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1; tick(3); iReset = 1'b0; tick(2);
    checks++;
    if ({oBusy, oAtTarget, oError, oRead, oWrite} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 00000", {oBusy, oAtTarget, oError, oRead, oWrite});
    end
    checks++;
    if (oCurFreq !== 32'd0 || oStatus !== 32'd0) begin
      failures++;
      $display("FAIL reset_words: got cur=%0d status=%0d, required 0 0", oCurFreq, oStatus);
    end
    checks++;
    if (oAddr !== 2'd0 || oWdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%0d wdata=%0d, required 0 0", oAddr, oWdata);
    end
  endtask

  task automatic test_ramp_up(input logic [31:0] t);
    int s;
    bit ok;
    log_q.delete(); exp_q.delete();
    exp_start(t);
    iTargetFreq = t; s = cyc;
    pulse_start();
    wait_hold(3000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ramp_hold: oAtTarget=0 after budget, required 1"); end
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL ramp_len: got %0d ops, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].rd !== exp_q[i].rd || log_q[i].addr !== exp_q[i].addr ||
          log_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL ramp_op[%0d]: got rd=%0b addr=%0d data=%0d, required rd=%0b addr=%0d data=%0d",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
      end
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].cyc !== s + 1 + i) begin
        failures++;
        $display("FAIL start_timing[%0d]: got cyc %0d, required %0d", i, log_q[i].cyc, s + 1 + i);
      end
    end
    for (int i = 5; i + 1 < log_q.size(); i += 2) begin
      checks++;
      if (log_q[i].cyc - log_q[i-2].cyc !== CAD || log_q[i+1].cyc !== log_q[i].cyc + 1) begin
        failures++;
        $display("FAIL ramp_cadence[%0d]: got gap %0d read_after %0d, required %0d 1",
                 i, log_q[i].cyc - log_q[i-2].cyc, log_q[i+1].cyc - log_q[i].cyc, CAD);
      end
    end
    checks++;
    if (oCurFreq !== t || oStatus !== last_status || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL ramp_end: got cur=%0d status=%h busy=%0b, required %0d %h 1",
               oCurFreq, oStatus, oBusy, t, last_status);
    end
    cur_model = t;
  endtask

  task automatic test_retarget(input logic [31:0] t);
    int s;
    bit ok;
    log_q.delete(); exp_q.delete();
    exp_ramp(cur_model, t);
    iTargetFreq = t; s = cyc;
    tick(1);
    checks++;
    if (oAtTarget !== 1'b0) begin failures++; $display("FAIL retarget_leave: got oAtTarget=%0b, required 0", oAtTarget); end
    wait_hold(3000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL retarget_hold: oAtTarget=0 after budget, required 1"); end
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL retarget_len: got %0d ops, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].rd !== exp_q[i].rd || log_q[i].addr !== exp_q[i].addr ||
          log_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL retarget_op[%0d]: got rd=%0b addr=%0d data=%0d, required rd=%0b addr=%0d data=%0d",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
      end
    end
    if (log_q.size() > 0) begin
      checks++;
      if (log_q[0].cyc !== s + int'(PER) + 2) begin
        failures++;
        $display("FAIL retarget_latency: got cyc %0d, required %0d", log_q[0].cyc, s + int'(PER) + 2);
      end
    end
    checks++;
    if (oCurFreq !== t) begin failures++; $display("FAIL retarget_cur: got %0d, required %0d", oCurFreq, t); end
    cur_model = t;
  endtask

  task automatic test_stop_wait();
    logic [31:0] t, f1;
    int sc, d;
    t  = cur_model + 32'd20000 + $urandom_range(0, 10000);
    f1 = cur_model + STEP;
    log_q.delete();
    iTargetFreq = t;
    for (int i = 0; i < 200 && log_q.size() < 2; i++) tick(1);
    d = $urandom_range(0, int'(PER) - 1);
    tick(1 + d);
    iStop = 1'b1; sc = cyc; tick(1); iStop = 1'b0;
    checks++;
    if (oBusy !== 1'b1) begin failures++; $display("FAIL stop_busy_dis: got %0b, required 1", oBusy); end
    tick(1);
    checks++;
    if (oBusy !== 1'b0) begin failures++; $display("FAIL stop_busy_fall: got %0b, required 0", oBusy); end
    tick(20);
    checks++;
    if (log_q.size() !== 3) begin
      failures++;
      $display("FAIL stop_len: got %0d ops, required 3", log_q.size());
    end else begin
      checks++;
      if (log_q[0].data !== f1 || log_q[2].rd !== 1'b0 || log_q[2].addr !== 2'd2 ||
          log_q[2].data !== 32'd0 || log_q[2].cyc !== sc + 1) begin
        failures++;
        $display("FAIL stop_ops: got f=%0d dis addr=%0d data=%0d cyc=%0d, required f=%0d addr=2 data=0 cyc=%0d",
                 log_q[0].data, log_q[2].addr, log_q[2].data, log_q[2].cyc, f1, sc + 1);
      end
    end
    checks++;
    if (oCurFreq !== f1) begin failures++; $display("FAIL stop_cur: got %0d, required %0d", oCurFreq, f1); end
    cur_model = f1;
  endtask

  task automatic test_priority();
    bit ok;
    logic [31:0] t;
    log_q.delete();
    iStart = 1'b1; iStop = 1'b1; tick(1); iStart = 1'b0; iStop = 1'b0;
    tick(20);
    checks++;
    if (log_q.size() !== 0 || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL prio_start_stop: got %0d ops busy=%0b, required 0 ops busy=0", log_q.size(), oBusy);
    end
    t = $urandom_range(3001, 6000);
    log_q.delete(); exp_q.delete();
    exp_start(t);
    iTargetFreq = t;
    pulse_start();
    tick($urandom_range(3, 12));
    pulse_start();
    wait_hold(3000, ok);
    checks++;
    if (!ok || log_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL prio_busy_len: got hold=%0b ops=%0d, required 1 %0d", ok, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].rd !== exp_q[i].rd || log_q[i].addr !== exp_q[i].addr ||
          log_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL prio_op[%0d]: got rd=%0b addr=%0d data=%0d, required rd=%0b addr=%0d data=%0d",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
      end
    end
    cur_model = t;
  endtask

  task automatic test_stop_hold();
    iStop = 1'b1; tick(1); iStop = 1'b0;
    checks++;
    if (oWrite !== 1'b1 || oAddr !== 2'd2 || oWdata !== 32'd0) begin
      failures++;
      $display("FAIL hold_stop_dis: got wr=%0b addr=%0d data=%0d, required 1 2 0", oWrite, oAddr, oWdata);
    end
    tick(1);
    checks++;
    if (oBusy !== 1'b0 || oCurFreq !== cur_model) begin
      failures++;
      $display("FAIL hold_stop_idle: got busy=%0b cur=%0d, required 0 %0d", oBusy, oCurFreq, cur_model);
    end
  endtask

  task automatic test_error();
    logic [31:0] t;
    int n, rd, idx, e;
    bit ok;
    t = $urandom_range(3001, 8000);
    n = $urandom_range(1, 3);
    log_q.delete(); exp_q.delete();
    exp_start(t);
    rd = 0; idx = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].rd && rd < n) begin rd++; idx = i; end
    while (exp_q.size() > idx + 1) exp_q.pop_back();
    push_op(1'b0, 2'd2, 32'd0);
    err_on_read = reads_seen + n; err_armed = 1'b1;
    iTargetFreq = t;
    pulse_start();
    e = -1;
    for (int i = 0; i < 500 && e < 0; i++) begin tick(1); if (oError) e = cyc; end
    checks++;
    if (e < 0) begin failures++; $display("FAIL err_set: oError=0 after budget, required 1"); end
    tick(3);
    checks++;
    if (oBusy !== 1'b0 || oError !== 1'b1) begin
      failures++;
      $display("FAIL err_state: got busy=%0b err=%0b, required 0 1", oBusy, oError);
    end
    tick(10);
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL err_len: got %0d ops, required %0d", log_q.size(), exp_q.size());
    end else begin
      checks++;
      if (log_q[idx+1].cyc !== log_q[idx].cyc + LAT + 1 || log_q[idx+1].cyc !== e) begin
        failures++;
        $display("FAIL err_timing: got dis cyc %0d err cyc %0d, required %0d", log_q[idx+1].cyc, e,
                 log_q[idx].cyc + LAT + 1);
      end
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].rd !== exp_q[i].rd || log_q[i].addr !== exp_q[i].addr ||
          log_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL err_op[%0d]: got rd=%0b addr=%0d data=%0d, required rd=%0b addr=%0d data=%0d",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
      end
    end
    err_armed = 1'b0;
    log_q.delete(); exp_q.delete();
    exp_start(t);
    pulse_start();
    checks++;
    if (oError !== 1'b0 || oWrite !== 1'b1 || oWdata !== START) begin
      failures++;
      $display("FAIL err_restart: got err=%0b wr=%0b data=%0d, required 0 1 %0d", oError, oWrite, oWdata, START);
    end
    wait_hold(3000, ok);
    checks++;
    if (!ok || log_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL err_rerun: got hold=%0b ops=%0d, required 1 %0d", ok, log_q.size(), exp_q.size());
    end
    cur_model = t;
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    iTargetFreq = cur_model + 32'd5000;
    for (int i = 0; i < 200 && log_q.size() < 1; i++) tick(1);
    tick(1);
    iReset = 1'b1; tick(1);
    checks++;
    if ({oBusy, oAtTarget, oError, oRead, oWrite} !== 5'b0 || oCurFreq !== 32'd0 ||
        oStatus !== 32'd0 || oAddr !== 2'd0 || oWdata !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outputs: got flags=%b cur=%0d status=%0d addr=%0d wdata=%0d, required all 0",
               {oBusy, oAtTarget, oError, oRead, oWrite}, oCurFreq, oStatus, oAddr, oWdata);
    end
    iReset = 1'b0;
    tick(20);
    checks++;
    if (log_q.size() !== 2) begin
      failures++;
      $display("FAIL midreset_nodis: got %0d ops, required 2 (freq write and read only)", log_q.size());
    end
    cur_model = '0;
  endtask

  initial begin
    logic [31:0] t;
    test_reset();
    test_ramp_up(32'd2500);
    test_retarget(32'd500);
    t = $urandom_range(0, 9000);
    if (t == cur_model) t = t + 32'd1;
    test_retarget(t);
    test_stop_wait();
    test_priority();
    test_stop_hold();
    test_error();
    test_reset_mid();
    test_ramp_up($urandom_range(1, 9000));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bldcm_ramp_master.md
# bldcm_ramp_master

Avalon-MM initiator that drives the register interface of the BLDC motor driver block (mBldcm) to perform speed ramps. It takes a target commutation frequency and start/stop commands from control logic. It issues single-cycle writes to the driver's frequency and enable registers, stepping toward the target at a programmable rate. After every frequency step it reads back the driver's status register. It sits between a host/control FSM and the driver's Avalon-MM slave port, in the same clock domain.

## Interface
- pStepSize, 32'd1000, frequency increment per ramp step (must be ≥ 1)
- pStepPeriod, 32'd50000, clock cycles spent in WAIT between steps (must be ≥ 1)
- pStartFreq, 32'd0, first frequency written on start
- pReadLatency, 1, cycles from oRead strobe to valid iRdata/iResp (1..3)

Ports:
- iClock  in  1  single clock; all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  pulse: begin ramp (ignored while oBusy, except in ERROR)
- iStop  in  1  pulse: abort/stop; has priority over iStart in the same cycle
- iTargetFreq  in  32  target frequency word; sampled every step
- oBusy  out  1  high in every state except IDLE and ERROR
- oAtTarget  out  1  high in HOLD
- oError  out  1  sticky; set by non-zero read response
- oCurFreq  out  32  last frequency value written to the driver
- oStatus  out  32  last status word read (addr 3)
- oAddr  out  2  word address: 0 = freq, 2 = enable, 3 = status
- oRead  out  1  single-cycle read strobe
- iRdata  in  32  read data from slave
- oWrite  out  1  single-cycle write strobe
- oWdata  out  32  write data
- iResp  in  2  slave response; 2'b00 = OK

## Operation
- States: IDLE, WR_FREQ, WR_EN, WAIT, STEP, RD_STAT, RD_WAIT, HOLD, WR_DIS, ERROR.
- IDLE + iStart: cur = pStartFreq.
- IDLE → WR_FREQ (write cur to addr 0) → WR_EN (write 1 to addr 2) → RD_STAT.
- WAIT: counter runs pStepPeriod cycles, then → STEP.
- STEP: compute next from cur and T = iTargetFreq, using 33-bit differences with no wrap.
  - If cur < T: next = min(cur + pStepSize, T).
  - If cur > T: next = max(cur − pStepSize, T).
  - Then → WR_FREQ, which writes next to addr 0 and updates oCurFreq.
- From WR_FREQ in ramp: → RD_STAT (read addr 3) → RD_WAIT.
- RD_WAIT: waits pReadLatency cycles, then captures oStatus and checks iResp.
  - iResp ≠ 0: set oError, → WR_DIS.
  - Else if cur == iTargetFreq: → HOLD.
  - Else: → WAIT.
- HOLD: oAtTarget = 1. If iTargetFreq ≠ cur, → WAIT, which restarts the ramp.
- iStop in any busy state: the current strobe cycle completes. Any outstanding read finishes RD_WAIT, and its data is discarded. Then → WR_DIS.
- WR_DIS: writes 0 to addr 2.
  - Without error: → IDLE, oCurFreq retained.
  - With error: → ERROR.
- ERROR: bus idle, oError = 1. iStart clears oError and behaves as from IDLE. iStop is ignored.
- Exactly one of oRead/oWrite is high in a bus cycle; oAddr/oWdata are valid only with a strobe and are 0 otherwise.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. iReset mid-transaction abandons it immediately; no disable write is issued.
- Start latency: first oWrite (addr 0) occurs the cycle after iStart is sampled. The enable write follows 1 cycle later. oRead (addr 3) follows 1 cycle after that.
- Status capture: pReadLatency cycles after the oRead cycle.
- Step cadence: pStepPeriod + 3 + pReadLatency cycles, from one freq write to the next (WAIT + STEP + WR_FREQ + RD_STAT + RD_WAIT).
- oCurFreq updates in the same cycle as its oWrite strobe.
- oAtTarget rises the cycle after the matching status capture. It falls on the cycle HOLD is left.
- No waitrequest: the slave must accept every strobe in one cycle.

## Test plan
- **Ramp up:** pStepSize = 1000, pStepPeriod = 4, pStartFreq = 0, T = 2500, pulse iStart.
  - Writes, in order: addr0 = 0, addr2 = 1, then addr0 = 1000, 2000, 2500.
  - Each freq write is followed by a read of addr3.
  - Successive freq writes are 8 cycles apart with pReadLatency = 1.
  - oAtTarget = 1 after the last status read.
- **Retarget down:** in HOLD at 2500, set T = 500.
  - Freq writes 1500, then 500; oAtTarget returns to 1.
  - No enable write is issued.
- **Stop mid-ramp:** iStop during WAIT.
  - Next bus op is write addr2 = 0; no further freq writes.
  - oBusy falls the following cycle; oCurFreq holds its last value.
- **Error:** slave returns iResp = 2'b10 on a status read.
  - oError = 1, then write addr2 = 0, then ERROR with oBusy = 0.
  - A following iStart clears oError and restarts from addr0 = pStartFreq.
- **Priority:** iStart and iStop high together in IDLE → no bus activity. iStart while busy → ignored.
- **Reset:** assert iReset during RD_WAIT → all outputs 0 next cycle and no disable write.
  - After reset, iStart produces a normal ramp.
